// File: rtl/muxn_pipe.sv
// N-way signed word selector feeding a 2-entry skid FIFO with valid/ready handshakes on both sides.
// Optional sticky out-of-range select flag (port sel_err) is built only when MUXN_PIPE_SELERR_EN is defined.
module muxn_pipe #(
    parameter  int NUM_IN     = 3,
    parameter  int DATA_WIDTH = 32,
    localparam int SEL_W      = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]               select,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [DATA_WIDTH-1:0]   dout,
    output logic                           out_valid,
    input  logic                           out_ready
`ifdef MUXN_PIPE_SELERR_EN
    ,
    output logic                           sel_err
`endif
);

    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_headData;
    logic [DATA_WIDTH-1:0] r_tailData;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_accept;
    logic                  w_consume;

    // Out-of-range selects fall through to the last channel because it is the default.
    always_comb begin
        w_word = din[(NUM_IN-1)*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < NUM_IN - 1; k++) begin
            if (select == SEL_W'(k)) begin
                w_word = din[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // in_ready is forced low while reset is held, independent of the clock.
    assign in_ready  = (r_count < 2'd2) && !rst;
    assign out_valid = (r_count != 2'd0);
    assign dout      = r_headData;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_headData <= '0;
            r_tailData <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_accept) begin
                        r_headData <= w_word;
                        r_count    <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({w_accept, w_consume})
                        2'b11: r_headData <= w_word;
                        2'b10: begin
                            r_tailData <= w_word;
                            r_count    <= 2'd2;
                        end
                        2'b01: r_count <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // Full: nothing can be accepted, so only a drain moves the tail forward.
                    if (w_consume) begin
                        r_headData <= r_tailData;
                        r_count    <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

`ifdef MUXN_PIPE_SELERR_EN
    localparam logic [SEL_W:0] NUM_IN_V = (SEL_W+1)'(NUM_IN);

    logic w_outOfRange;
    logic r_selErr;

    assign w_outOfRange = ({1'b0, select} >= NUM_IN_V);
    assign sel_err      = r_selErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_selErr <= 1'b0;
        end else if (w_accept && w_outOfRange) begin
            r_selErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Testbench for muxn_pipe: directed checks on a 3x32 instance and a seeded random run on a 5x16 instance
// against a queue-based reference model.
module tb_muxn_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 3-input, 32-bit instance for directed scenarios.
    logic [95:0] a_din;
    logic [1:0]  a_sel;
    logic        a_inv, a_irdy, a_ovalid, a_ordy, a_err;
    logic [31:0] a_dout;

    // 5-input, 16-bit instance for the random scoreboard run.
    logic [79:0] b_din;
    logic [2:0]  b_sel;
    logic        b_inv, b_irdy, b_ovalid, b_ordy, b_err;
    logic [15:0] b_dout;

    int checks = 0;
    int errors = 0;

    muxn_pipe #(.NUM_IN(3), .DATA_WIDTH(32)) u_dut3 (
        .clk(clk), .rst(rst), .din(a_din), .select(a_sel),
        .in_valid(a_inv), .in_ready(a_irdy), .dout(a_dout),
        .out_valid(a_ovalid), .out_ready(a_ordy)
`ifdef MUXN_PIPE_SELERR_EN
        , .sel_err(a_err)
`endif
    );

    muxn_pipe #(.NUM_IN(5), .DATA_WIDTH(16)) u_dut5 (
        .clk(clk), .rst(rst), .din(b_din), .select(b_sel),
        .in_valid(b_inv), .in_ready(b_irdy), .dout(b_dout),
        .out_valid(b_ovalid), .out_ready(b_ordy)
`ifdef MUXN_PIPE_SELERR_EN
        , .sel_err(b_err)
`endif
    );

`ifndef MUXN_PIPE_SELERR_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic inv, input logic [1:0] sel, input logic ordy);
        a_inv  = inv;
        a_sel  = sel;
        a_ordy = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random run: stored beats in acceptance order.
    logic [15:0] model[$];
    logic [15:0] expWord, prevDout;
    logic        acc, con, prevValid, prevOrdy, sawOob;

    initial begin
        rst = 1'b1;
        a_din = '0; b_din = '0; b_sel = '0; b_inv = 1'b0; b_ordy = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0);
        #12;
        checkOutput("reset out_valid", {63'd0, a_ovalid}, 64'd0);
        checkOutput("reset dout", {32'd0, a_dout}, 64'd0);
        checkOutput("reset in_ready", {63'd0, a_irdy}, 64'd0);
`ifdef MUXN_PIPE_SELERR_EN
        checkOutput("reset sel_err", {63'd0, a_err}, 64'd0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("release in_ready", {63'd0, a_irdy}, 64'd1);

        // Straight-through selection with out_ready held high.
        a_din = {32'hFFFFFFFB, 32'h7FFFFFFF, 32'h12345678};
        applyStimulus(1'b1, 2'd0, 1'b1);
        tick();
        checkOutput("sel0 dout", {32'd0, a_dout}, 64'h12345678);
        checkOutput("sel0 valid", {63'd0, a_ovalid}, 64'd1);
        applyStimulus(1'b1, 2'd1, 1'b1);
        tick();
        checkOutput("sel1 dout", {32'd0, a_dout}, 64'h7FFFFFFF);
        checkOutput("sel1 in_ready", {63'd0, a_irdy}, 64'd1);
        applyStimulus(1'b1, 2'd2, 1'b1);
        tick();
        checkOutput("sel2 dout", {32'd0, a_dout}, 64'hFFFFFFFB);
        checkOutput("sel2 in_ready", {63'd0, a_irdy}, 64'd1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("drain valid", {63'd0, a_ovalid}, 64'd0);

        // Backpressure: fill to two entries, hold, then drain.
        a_din = {32'd0, 32'd0, 32'd1};
        applyStimulus(1'b1, 2'd0, 1'b0);
        tick();
        checkOutput("bp1 in_ready", {63'd0, a_irdy}, 64'd1);
        a_din[31:0] = 32'd2;
        tick();
        checkOutput("bp2 in_ready", {63'd0, a_irdy}, 64'd0);
        checkOutput("bp2 dout", {32'd0, a_dout}, 64'd1);
        a_din[31:0] = 32'd3;
        tick();
        checkOutput("bp3 hold in_ready", {63'd0, a_irdy}, 64'd0);
        checkOutput("bp3 hold dout", {32'd0, a_dout}, 64'd1);
        applyStimulus(1'b1, 2'd0, 1'b1);
        tick();
        checkOutput("bp4 dout", {32'd0, a_dout}, 64'd2);
        checkOutput("bp4 in_ready", {63'd0, a_irdy}, 64'd1);
        tick();
        checkOutput("bp5 dout", {32'd0, a_dout}, 64'd3);
        checkOutput("bp5 valid", {63'd0, a_ovalid}, 64'd1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("bp6 valid", {63'd0, a_ovalid}, 64'd0);

        // Out-of-range select maps to the last channel.
        a_din = {32'h000000AA, 32'h00000055, 32'h00000011};
        applyStimulus(1'b1, 2'd3, 1'b1);
        tick();
        checkOutput("oob dout", {32'd0, a_dout}, 64'hAA);
`ifdef MUXN_PIPE_SELERR_EN
        checkOutput("oob sel_err", {63'd0, a_err}, 64'd1);
`endif
        applyStimulus(1'b1, 2'd1, 1'b1);
        tick();
        checkOutput("legal after oob dout", {32'd0, a_dout}, 64'h55);
`ifdef MUXN_PIPE_SELERR_EN
        checkOutput("sel_err sticky", {63'd0, a_err}, 64'd1);
`endif
        applyStimulus(1'b0, 2'd0, 1'b1);
        tick();

        // Fill with 7 and 8, then reset asynchronously between edges.
        a_din = {32'd0, 32'd0, 32'd7};
        applyStimulus(1'b1, 2'd0, 1'b0);
        tick();
        a_din[31:0] = 32'd8;
        tick();
        checkOutput("full dout", {32'd0, a_dout}, 64'd7);
        checkOutput("full in_ready", {63'd0, a_irdy}, 64'd0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst valid", {63'd0, a_ovalid}, 64'd0);
        checkOutput("async rst dout", {32'd0, a_dout}, 64'd0);
        checkOutput("async rst in_ready", {63'd0, a_irdy}, 64'd0);
`ifdef MUXN_PIPE_SELERR_EN
        checkOutput("async rst sel_err", {63'd0, a_err}, 64'd0);
`endif
        #1 rst = 1'b0;
        #1;
        checkOutput("post rst in_ready", {63'd0, a_irdy}, 64'd1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post rst no ghost", {63'd0, a_ovalid}, 64'd0);
        end

        // Seeded random traffic on the 5-input instance.
        void'($urandom(32'd20240611));
        prevValid = 1'b0; prevOrdy = 1'b0; prevDout = '0; sawOob = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checkOutput("rand valid", {63'd0, b_ovalid}, {63'd0, model.size() > 0});
            checkOutput("rand in_ready", {63'd0, b_irdy}, {63'd0, model.size() < 2});
            if (model.size() > 0) checkOutput("rand dout", {48'd0, b_dout}, {48'd0, model[0]});
            if (prevValid && !prevOrdy) checkOutput("rand stable", {48'd0, b_dout}, {48'd0, prevDout});
            if (errors > 20) break;

            b_inv  = 1'($urandom_range(0, 1));
            b_ordy = 1'($urandom_range(0, 1));
            b_sel  = 3'($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) b_din[k*16 +: 16] = 16'($urandom);

            expWord = (b_sel < 3'd5) ? b_din[int'(b_sel)*16 +: 16] : b_din[64 +: 16];
            acc = b_inv && (model.size() < 2);
            con = b_ordy && (model.size() > 0);
            if (acc && b_sel >= 3'd5) sawOob = 1'b1;
            if (con) void'(model.pop_front());
            if (acc) model.push_back(expWord);

            prevValid = b_ovalid;
            prevOrdy  = b_ordy;
            prevDout  = b_dout;
            tick();
        end
`ifdef MUXN_PIPE_SELERR_EN
        checkOutput("rand sel_err", {63'd0, b_err}, {63'd0, sawOob});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muxn_pipe.md
MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
REQ-001 Parameter NUM_IN, default 3, number of data inputs; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32, width of each signed data word.
REQ-003 Localparam SEL_W = max(1, clog2(NUM_IN)), the select width; not user-settable.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 din  input  NUM_IN*DATA_WIDTH  packed signed inputs; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 select  input  SEL_W  channel index, sampled with the input beat.
REQ-008 in_valid  input  1  input beat offered.
REQ-009 in_ready  output  1  block can accept a beat this cycle.
REQ-010 dout  output  DATA_WIDTH  signed selected word at the head of the output queue.
REQ-011 out_valid  output  1  dout holds a valid beat.
REQ-012 out_ready  input  1  downstream consumes dout this cycle.
REQ-013 sel_err  output  1  sticky out-of-range-select flag; present only per REQ-030.

Function
REQ-014 Input handshake: a beat is accepted on a rising edge where in_valid=1 and in_ready=1; otherwise din and select are ignored.
REQ-015 Selection: select<NUM_IN stores channel select; select>=NUM_IN stores channel NUM_IN-1.
REQ-016 The selected word is stored bit-exact; no sign extension, truncation or arithmetic.
REQ-017 Storage: 2-entry FIFO (skid buffer) with occupancy count 0..2.
REQ-018 in_ready = 1 when count<2 and rst=0; in_ready does not depend on in_valid.
REQ-019 out_valid = 1 when count>=1; dout is the oldest stored entry.
REQ-020 Output handshake: a beat is consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-021 Latency: a beat accepted into an empty block appears on dout with out_valid=1 in the next cycle.
REQ-022 Simultaneous accept and consume at count=1: count stays 1 and dout shows the new beat in the next cycle.
REQ-023 Accept at count=1 without consume: count becomes 2 and in_ready deasserts in the next cycle.
REQ-024 Consume at count=2 (accept impossible): count becomes 1, the second entry moves to the head and in_ready reasserts.
REQ-025 Beats leave in acceptance order with no loss or duplication; at count=0 out_ready is ignored.
REQ-026 dout is held stable while out_valid=1 and out_ready=0.

Reset
REQ-027 When rst is asserted, immediately and asynchronously: count=0, out_valid=0, dout=0, in_ready=0, sel_err=0.
REQ-028 Reset asserted mid-operation discards all stored beats; in_ready returns to 1 on the first cycle with rst=0.
REQ-029 Behaviour after reset is independent of any traffic before reset.

Configuration
REQ-030 Macro MUXN_PIPE_SELERR_EN defined: port sel_err exists. It is set on the edge after any beat is accepted with select>=NUM_IN, stays 1 until reset, and does not change data behaviour.
REQ-031 Macro MUXN_PIPE_SELERR_EN undefined: port sel_err and its logic are absent; out-of-range selects map to channel NUM_IN-1 with no indication.

Verification
REQ-032 NUM_IN=3, DATA_WIDTH=32, out_ready=1, din={ch2=-5, ch1=0x7FFFFFFF, ch0=0x12345678}, select=0,1,2 on consecutive cycles -> dout=0x12345678, 0x7FFFFFFF, 0xFFFFFFFB one cycle after each accept; count never exceeds 1.
REQ-033 out_ready=0, three beats offered with values 1, 2, 3 -> two accepted, in_ready=0 from the cycle after the second accept; raising out_ready -> dout=1 then 2; beat 3 accepted once in_ready reasserts.
REQ-034 NUM_IN=3, select=3 with ch2=0xAA -> dout=0xAA; with MUXN_PIPE_SELERR_EN, sel_err=1 the next cycle and it holds through later legal selects.
REQ-035 count=2 holding beats 7 and 8, rst pulsed between clock edges -> out_valid, dout and in_ready drop to 0 without waiting for a clock edge; after release, in_ready=1, out_valid=0 and beats 7 and 8 never appear.
REQ-036 Random in_valid/out_ready (seeded, 10000 cycles, NUM_IN=5, DATA_WIDTH=16) against a scoreboard -> output order and values match, and dout is stable whenever out_valid=1 and out_ready=0.
